// File: rtl/i2s_receive_axis.sv
// I2S slave receiver with an AXI4-Stream master output.
// sck/ws/sd are sampled on M_AXIS_ACLK. sck is never used as a clock.
// Each stereo frame goes out as a left beat (TLAST=0) followed by a right beat (TLAST=1).
// Optional feature: define I2S_RX_OVF_CNT_EN to add the ovf_count port, a saturating
// 16-bit count of dropped frames.
module i2s_receive_axis #(
    parameter int unsigned DATA_WIDTH = 32
) (
    input  logic                  M_AXIS_ACLK,
    input  logic                  M_AXIS_ARESETN,
    input  logic                  sck,
    input  logic                  ws,
    input  logic                  sd,
    output logic                  M_AXIS_TVALID,
    output logic [DATA_WIDTH-1:0] M_AXIS_TDATA,
    output logic                  M_AXIS_TLAST,
    input  logic                  M_AXIS_TREADY,
`ifdef I2S_RX_OVF_CNT_EN
    output logic [15:0]           ovf_count,
`endif
    output logic                  overflow
);

    localparam int unsigned CW = $clog2(DATA_WIDTH + 1);
    localparam int unsigned IW = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;

    typedef enum logic [1:0] {StIdle, StSendL, StSendR} state_e;

    logic [1:0]            sck_sync_q, ws_sync_q, sd_sync_q;
    logic                  sck_prev_q;
    logic                  sck_s, ws_s, sd_s;
    logic                  sck_rise, ws_edge, frame_evt;

    logic                  ws_prev_q;
    logic                  aligned_q;
    logic                  left_valid_q;
    logic [CW-1:0]         bitcnt_q;
    logic [DATA_WIDTH-1:0] word_q;
    logic [DATA_WIDTH-1:0] word_ins;
    logic [IW-1:0]         bit_idx;
    logic [DATA_WIDTH-1:0] left_hold_q;

    logic [DATA_WIDTH-1:0] pair_l_q, pair_r_q;
    state_e                state_q, state_d;
    logic                  load_pair, drop;
    logic                  overflow_q;

    // Two-flop synchronisers on all I2S inputs, plus sck history for rise detection.
    always_ff @(posedge M_AXIS_ACLK or negedge M_AXIS_ARESETN) begin
        if (!M_AXIS_ARESETN) begin
            sck_sync_q <= '0;
            ws_sync_q  <= '0;
            sd_sync_q  <= '0;
            sck_prev_q <= 1'b0;
        end else begin
            sck_sync_q <= {sck_sync_q[0], sck};
            ws_sync_q  <= {ws_sync_q[0], ws};
            sd_sync_q  <= {sd_sync_q[0], sd};
            sck_prev_q <= sck_sync_q[1];
        end
    end

    assign sck_s    = sck_sync_q[1];
    assign ws_s     = ws_sync_q[1];
    assign sd_s     = sd_sync_q[1];
    assign sck_rise = sck_s & ~sck_prev_q;
    assign ws_edge  = sck_rise & (ws_s != ws_prev_q);
    // A right word closes a frame only if a complete left word precedes it.
    assign frame_evt = ws_edge & ws_prev_q & aligned_q & left_valid_q;

    // Current word with the sampled bit merged in. Bits past DATA_WIDTH are dropped.
    always_comb begin
        word_ins = word_q;
        bit_idx  = IW'(DATA_WIDTH - 1) - IW'(bitcnt_q);
        if (bitcnt_q < CW'(DATA_WIDTH)) begin
            word_ins[bit_idx] = sd_s;
        end
    end

    // Deserialiser. A ws change marks the LSB slot of the previous channel (one-bit delay).
    always_ff @(posedge M_AXIS_ACLK or negedge M_AXIS_ARESETN) begin
        if (!M_AXIS_ARESETN) begin
            ws_prev_q    <= 1'b0;
            aligned_q    <= 1'b0;
            left_valid_q <= 1'b0;
            bitcnt_q     <= '0;
            word_q       <= '0;
            left_hold_q  <= '0;
        end else if (sck_rise) begin
            ws_prev_q <= ws_s;
            if (ws_s != ws_prev_q) begin
                if (!ws_prev_q) begin
                    if (aligned_q) begin
                        left_hold_q  <= word_ins;
                        left_valid_q <= 1'b1;
                    end
                end else begin
                    left_valid_q <= 1'b0;
                end
                word_q    <= '0;
                bitcnt_q  <= '0;
                aligned_q <= 1'b1;
            end else begin
                word_q <= word_ins;
                if (bitcnt_q < CW'(DATA_WIDTH)) begin
                    bitcnt_q <= bitcnt_q + CW'(1);
                end
            end
        end
    end

    // Output FSM state register.
    always_ff @(posedge M_AXIS_ACLK or negedge M_AXIS_ARESETN) begin
        if (!M_AXIS_ARESETN) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    // Next state. A frame arriving while a pair is still in flight is dropped.
    always_comb begin
        state_d   = state_q;
        load_pair = 1'b0;
        drop      = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (frame_evt) begin
                    state_d   = StSendL;
                    load_pair = 1'b1;
                end
            end
            StSendL: begin
                drop = frame_evt;
                if (M_AXIS_TREADY) state_d = StSendR;
            end
            StSendR: begin
                drop = frame_evt;
                if (M_AXIS_TREADY) state_d = StIdle;
            end
            default: state_d = StIdle;
        endcase
    end

    // Pair holding registers and the sticky overflow flag.
    always_ff @(posedge M_AXIS_ACLK or negedge M_AXIS_ARESETN) begin
        if (!M_AXIS_ARESETN) begin
            pair_l_q   <= '0;
            pair_r_q   <= '0;
            overflow_q <= 1'b0;
        end else begin
            if (load_pair) begin
                pair_l_q <= left_hold_q;
                pair_r_q <= word_ins;
            end
            if (drop) overflow_q <= 1'b1;
        end
    end

`ifdef I2S_RX_OVF_CNT_EN
    logic [15:0] ovf_count_q;

    // Saturating count of dropped frames.
    always_ff @(posedge M_AXIS_ACLK or negedge M_AXIS_ARESETN) begin
        if (!M_AXIS_ARESETN) begin
            ovf_count_q <= '0;
        end else if (drop && (ovf_count_q != 16'hFFFF)) begin
            ovf_count_q <= ovf_count_q + 16'd1;
        end
    end

    assign ovf_count = ovf_count_q;
`endif

    assign M_AXIS_TVALID = (state_q != StIdle);
    assign M_AXIS_TLAST  = (state_q == StSendR);
    assign M_AXIS_TDATA  = (state_q == StSendR) ? pair_r_q : pair_l_q;
    assign overflow      = overflow_q;

endmodule
